// File: rtl/r88_pkg.sv
// Shared definitions for the R88 ALU sequencer: opcodes, FSM encoding,
// the latched request bundle and the carry-update decode.
package r88_pkg;

  localparam logic [2:0] PASS = 3'd0;
  localparam logic [2:0] SHL  = 3'd1;
  localparam logic [2:0] SHR  = 3'd2;
  localparam logic [2:0] ADD  = 3'd3;
  localparam logic [2:0] SUB  = 3'd4;
  localparam logic [2:0] OR   = 3'd5;
  localparam logic [2:0] AND  = 3'd6;
  localparam logic [2:0] XOR  = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } stateT;

  typedef struct packed {
    logic [2:0] opCode;
    logic       useCarry;
    logic       invert;
    logic       decimal;
    logic       immSel;
  } reqT;

  // Only the shift and arithmetic ops produce a meaningful carry.
  function automatic logic updatesCarry(input logic [2:0] op);
    return (op >= SHL) && (op <= SUB);
  endfunction

endpackage

// File: rtl/r88_flag_reg.sv
// Carry/zero/negative flag storage; Z and N follow every capture,
// C only when the operation produces a carry.
module r88_flag_reg (
  input  logic       sysClock,
  input  logic       sysReset,
  input  logic       captureEn,
  input  logic       carryEn,
  input  logic [7:0] busData,
  input  logic       aluCarryOut,
  output logic       flagC,
  output logic       flagZ,
  output logic       flagN
);

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge sysClock) begin
    if (sysReset) begin
      flagC <= 1'b0;
      flagZ <= 1'b0;
      flagN <= 1'b0;
    end else if (captureEn) begin
      flagZ <= (busData == 8'h00);
      flagN <= busData[7];
      if (carryEn) flagC <= aluCarryOut;
    end
  end

endmodule

// File: rtl/r88_alu_seq.sv
// R88 ALU sequencer: accepts a request in IDLE, steps the ALU through
// EXEC and RESULT, then captures the bus and flags and pulses done.
module r88_alu_seq
  import r88_pkg::*;
(
  input  logic       sysClock,
  input  logic       sysReset,
  input  logic       start,
  input  logic [2:0] opCode,
  input  logic       useCarry,
  input  logic       invert,
  input  logic       decimal,
  input  logic       immSel,
  input  logic [7:0] busData,
  input  logic       aluCarryOut,
  output logic [2:0] aluOp,
  output logic       carryInEn,
  output logic       carryIn,
  output logic       invOut,
  output logic       decMode,
  output logic       rightSel,
  output logic       aluResult,
  output logic       busy,
  output logic       done,
  output logic       destWe,
  output logic [7:0] result,
  output logic       flagC,
  output logic       flagZ,
  output logic       flagN
);

  stateT state, stateNext;
  reqT   req;

  always_ff @(posedge sysClock) begin
    if (sysReset) state <= IDLE;
    else          state <= stateNext;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = EXEC;
      EXEC:    stateNext = RESULT;
      RESULT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge sysClock) begin
    if (sysReset) begin
      req <= '0;
    end else if (state == IDLE && start) begin
      req <= '{opCode: opCode, useCarry: useCarry, invert: invert,
               decimal: decimal, immSel: immSel};
    end
  end

  // done is registered off the RESULT state, so it lands in the IDLE
  // cycle that follows and a reset during RESULT suppresses it.
  always_ff @(posedge sysClock) begin
    if (sysReset) begin
      result <= 8'h00;
      done   <= 1'b0;
    end else begin
      done <= (state == RESULT);
      if (state == RESULT) result <= busData;
    end
  end

  always_comb begin
    aluOp     = 3'd0;
    carryInEn = 1'b0;
    carryIn   = 1'b0;
    invOut    = 1'b0;
    decMode   = 1'b0;
    rightSel  = 1'b0;
    aluResult = 1'b0;
    destWe    = 1'b0;
    busy      = (state != IDLE);
    if (state == EXEC || state == RESULT) begin
      aluOp     = req.opCode;
      carryInEn = req.useCarry;
      carryIn   = flagC;
      rightSel  = req.immSel;
      decMode   = req.decimal;
    end
    if (state == RESULT) begin
      aluResult = 1'b1;
      invOut    = req.invert;
      destWe    = 1'b1;
    end
  end

  r88_flag_reg uFlags (
    .sysClock    (sysClock),
    .sysReset    (sysReset),
    .captureEn   (state == RESULT),
    .carryEn     (updatesCarry(req.opCode)),
    .busData     (busData),
    .aluCarryOut (aluCarryOut),
    .flagC       (flagC),
    .flagZ       (flagZ),
    .flagN       (flagN)
  );

endmodule

// File: tb/tb_r88_alu_seq.sv
// Directed bench for r88_alu_seq: stimulus is applied and outputs are
// sampled on the falling edge, one operation phase per clock.
module tb_r88_alu_seq;

  logic       sysClock = 1'b0;
  logic       sysReset;
  logic       start;
  logic [2:0] opCode;
  logic       useCarry, invert, decimal, immSel;
  logic [7:0] busData;
  logic       aluCarryOut;
  logic [2:0] aluOp;
  logic       carryInEn, carryIn, invOut, decMode, rightSel, aluResult;
  logic       busy, done, destWe;
  logic [7:0] result;
  logic       flagC, flagZ, flagN;

  int checks   = 0;
  int failures = 0;
  logic modelC = 1'b0;

  always #5 sysClock = ~sysClock;

  r88_alu_seq dut (
    .sysClock(sysClock), .sysReset(sysReset), .start(start), .opCode(opCode),
    .useCarry(useCarry), .invert(invert), .decimal(decimal), .immSel(immSel),
    .busData(busData), .aluCarryOut(aluCarryOut), .aluOp(aluOp),
    .carryInEn(carryInEn), .carryIn(carryIn), .invOut(invOut),
    .decMode(decMode), .rightSel(rightSel), .aluResult(aluResult),
    .busy(busy), .done(done), .destWe(destWe), .result(result),
    .flagC(flagC), .flagZ(flagZ), .flagN(flagN)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idleCheck(input string tag);
    @(negedge sysClock);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".done"}, done, 1'b0);
    check({tag, ".destWe"}, destWe, 1'b0);
    check({tag, ".ctl"}, {aluOp, carryInEn, carryIn, invOut, decMode, rightSel, aluResult}, 9'd0);
  endtask

  // Entered on a falling edge with the DUT in IDLE (or in its done cycle);
  // returns on the falling edge of the done cycle.
  task automatic doOp(input string tag, input logic [2:0] op, input logic uc,
                      input logic inv, input logic dec, input logic imm,
                      input logic [7:0] bus, input logic cout, input logic pokeStart);
    start = 1'b1; opCode = op; useCarry = uc; invert = inv; decimal = dec; immSel = imm;
    busData = ~bus; aluCarryOut = ~cout;
    @(negedge sysClock);  // EXEC
    check({tag, ".x.busy"}, busy, 1'b1);
    check({tag, ".x.done"}, done, 1'b0);
    check({tag, ".x.aluOp"}, aluOp, op);
    check({tag, ".x.carryInEn"}, carryInEn, uc);
    check({tag, ".x.carryIn"}, carryIn, modelC);
    check({tag, ".x.rightSel"}, rightSel, imm);
    check({tag, ".x.decMode"}, decMode, dec);
    check({tag, ".x.aluResult"}, aluResult, 1'b0);
    check({tag, ".x.invOut"}, invOut, 1'b0);
    check({tag, ".x.destWe"}, destWe, 1'b0);
    start = pokeStart; opCode = ~op; useCarry = ~uc; invert = ~inv; decimal = ~dec; immSel = ~imm;
    @(negedge sysClock);  // RESULT
    check({tag, ".r.busy"}, busy, 1'b1);
    check({tag, ".r.aluOp"}, aluOp, op);
    check({tag, ".r.carryInEn"}, carryInEn, uc);
    check({tag, ".r.carryIn"}, carryIn, modelC);
    check({tag, ".r.rightSel"}, rightSel, imm);
    check({tag, ".r.decMode"}, decMode, dec);
    check({tag, ".r.aluResult"}, aluResult, 1'b1);
    check({tag, ".r.invOut"}, invOut, inv);
    check({tag, ".r.destWe"}, destWe, 1'b1);
    busData = bus; aluCarryOut = cout; start = pokeStart;
    @(negedge sysClock);  // done cycle
    start = 1'b0;
    if (op >= 3'd1 && op <= 3'd4) modelC = cout;
    check({tag, ".d.done"}, done, 1'b1);
    check({tag, ".d.busy"}, busy, 1'b0);
    check({tag, ".d.destWe"}, destWe, 1'b0);
    check({tag, ".d.result"}, result, bus);
    check({tag, ".d.flagC"}, flagC, modelC);
    check({tag, ".d.flagZ"}, flagZ, bus == 8'h00);
    check({tag, ".d.flagN"}, flagN, bus[7]);
  endtask

  initial begin
    sysReset = 1'b1; start = 1'b1; opCode = 3'd3; useCarry = 1'b1; invert = 1'b1;
    decimal = 1'b1; immSel = 1'b1; busData = 8'hFF; aluCarryOut = 1'b1;
    repeat (2) @(negedge sysClock);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.result", result, 8'h00);
    check("rst.flags", {flagC, flagZ, flagN}, 3'b000);
    check("rst.ctl", {aluOp, carryInEn, carryIn, invOut, decMode, rightSel, aluResult, destWe}, 10'd0);
    sysReset = 1'b0; start = 1'b0;
    idleCheck("rst.idle");

    doOp("add", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idleCheck("add.after");
    doOp("or", 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0);
    doOp("sub_b2b", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
    doOp("shl_poke", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1);
    idleCheck("poke.idle1");
    idleCheck("poke.idle2");
    doOp("pass_inv", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    idleCheck("inv.after");

    // Reset during RESULT aborts the operation.
    start = 1'b1; opCode = 3'd7; useCarry = 1'b0; invert = 1'b0; decimal = 1'b0; immSel = 1'b0;
    @(negedge sysClock);
    check("abort.x.busy", busy, 1'b1);
    start = 1'b0;
    @(negedge sysClock);
    check("abort.r.destWe", destWe, 1'b1);
    busData = 8'h55; aluCarryOut = 1'b1; sysReset = 1'b1;
    @(negedge sysClock);
    modelC = 1'b0;
    check("abort.result", result, 8'h00);
    check("abort.flags", {flagC, flagZ, flagN}, 3'b000);
    check("abort.done", done, 1'b0);
    check("abort.busy", busy, 1'b0);
    sysReset = 1'b0;
    idleCheck("abort.idle");

    doOp("and_post_rst", 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idleCheck("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/r88_alu_seq.md
R88_ALU_SEQ -- requirements
Module: r88_alu_seq

Interface
REQ-001 The block SHALL have these ports:
- sysClock  in  1  single system clock; all state updates on rising edge.
- sysReset  in  1  synchronous, active-high reset, sampled on rising sysClock.
- start  in  1  operation request, sampled in IDLE only.
- opCode  in  3  ALU operation code, latched on accept.
- useCarry  in  1  use flagC as ALU carry-in, latched on accept.
- invert  in  1  request inverted result on bus, latched on accept.
- decimal  in  1  decimal-mode request, latched on accept.
- immSel  in  1  right operand taken from internal bus, latched on accept.
- busData  in  8  internal data bus as observed by the sequencer.
- aluCarryOut  in  1  carry produced by the ALU.
- aluOp  out  3  operation code driven to the ALU.
- carryInEn, carryIn, invOut, decMode, rightSel, aluResult  out  1 each  ALU control strobes.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- destWe  out  1  destination register write strobe.
- result  out  8  last captured result.
- flagC, flagZ, flagN  out  1 each  carry, zero and negative flags.

Function
REQ-002 The FSM SHALL have exactly three states: IDLE, EXEC and RESULT.
REQ-003 In IDLE with start=1, the block SHALL latch opCode/useCarry/invert/decimal/immSel and enter EXEC on the next edge.
REQ-004 start in EXEC or RESULT SHALL be ignored and not queued.
REQ-005 In EXEC the block SHALL drive:
- aluOp = latched opCode
- carryInEn = latched useCarry
- carryIn = flagC
- rightSel = latched immSel
- decMode = latched decimal
- aluResult = 0
Then it SHALL enter RESULT.
REQ-006 In RESULT the block SHALL hold all EXEC controls and also drive:
- aluResult = 1
- invOut = latched invert
- destWe = 1
It SHALL then return to IDLE.
REQ-007 At the edge ending RESULT, the block SHALL capture busData into result; result therefore holds the post-inversion value.
REQ-008 At the same edge, flagZ SHALL become (busData==0) and flagN SHALL become busData[7], for every opCode.
REQ-009 flagC SHALL be loaded from aluCarryOut only for opCode 1–4 (SHL, SHR, ADD, SUB); for opCode 0 and 5–7 it SHALL hold its value.
REQ-010 done SHALL be 1 for exactly the one IDLE cycle following RESULT, and 0 in all other cycles.
REQ-011 Latency: with start accepted in cycle N, EXEC SHALL be cycle N+1, RESULT cycle N+2, and done cycle N+3.
REQ-012 A start arriving in the same cycle as done=1 SHALL be accepted, giving back-to-back throughput of one operation per 3 cycles.
REQ-013 In back-to-back operation, carryIn SHALL reflect flagC as updated by the previous operation.
REQ-014 busy SHALL be 1 in EXEC and RESULT and 0 in IDLE.
REQ-015 In IDLE, all ALU control outputs and destWe SHALL be 0.
REQ-016 Outputs SHALL be registered or decoded from the state register only, with no combinational path from start to any output.

Reset
REQ-017 With sysReset=1 at a rising edge, the block SHALL:
- enter IDLE
- clear result, flagC, flagZ, flagN and the latched request fields to 0
- force done=0
REQ-018 sysReset SHALL take priority over start.
REQ-019 A reset asserted in EXEC or RESULT SHALL abort the operation: no flag or result update, and no done pulse.
REQ-020 After reset deasserts, the first start SHALL be accepted normally.

Structure
REQ-021 A shared package r88_pkg SHALL define:
- ALU opcode constants: PASS=0, SHL=1, SHR=2, ADD=3, SUB=4, OR=5, AND=6, XOR=7
- the FSM state encoding
REQ-022 Flag storage and update SHALL be a sub-module r88_flag_reg, with inputs for capture enable, carry-update enable, busData and aluCarryOut.

Verification
REQ-023 ADD, flagC=0, useCarry=1; bench ALU returns busData=0x00 and aluCarryOut=1 -> carryIn=0 in EXEC; result=0x00, flagC=1, flagZ=1, flagN=0; done at cycle N+3.
REQ-024 OR (opCode 5) with flagC=1; busData=0x80, aluCarryOut=0 -> flagC stays 1, flagN=1, flagZ=0, destWe high exactly one cycle.
REQ-025 SUB accepted in the same cycle as the previous done -> accepted with no idle gap; carryIn equals flagC produced by the prior op.
REQ-026 start pulsed in EXEC and again in RESULT -> ignored; exactly one done pulse follows.
REQ-027 sysReset asserted during RESULT with busData=0x55 -> result=0x00, all flags 0, no done pulse, state IDLE.
REQ-028 invert=1, immSel=1 -> invOut=1 only in RESULT and rightSel=1 in EXEC and RESULT; result equals the busData value presented.
